// File: rtl/reg_map_pkg.sv
// Shared constants for the register-map write target: register addresses,
// completion error codes and the write-handshake state encoding.
package reg_map_pkg;

  localparam logic [7:0] REG_CHIRP_PERIOD = 8'h00;
  localparam logic [7:0] REG_DDC_DUC      = 8'h10;
  localparam logic [7:0] REG_ADC_PKT      = 8'h20;
  localparam logic [7:0] REG_MAC_SPEED    = 8'h23;
  localparam logic [7:0] REG_STATUS       = 8'hF0;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_RO       = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/reg_map_field.sv
// One control register: masked-write storage plus a one-cycle pulse that
// marks the cycle in which a write actually touched an implemented bit.
module reg_map_field
  import reg_map_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] RST   = '0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_keep,
  output logic [WIDTH-1:0] value,
  output logic             update
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             update_q, update_d;

  // Merge the new data into the stored value only where keep selects a bit.
  always_comb begin
    value_d  = value_q;
    update_d = 1'b0;
    if (wr_en) begin
      value_d  = (value_q & ~wr_keep) | (wr_data & wr_keep);
      update_d = |wr_keep;
    end
  end

  // Storage and pulse flops; reset restores the power-on value.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      value_q  <= RST;
      update_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      update_q <= update_d;
    end
  end

  assign value  = value_q;
  assign update = update_q;

endmodule

// File: rtl/reg_map_responder.sv
// Register-map write target: accepts single-cycle masked write commands,
// updates the control register file, returns a completion pulse with an
// error code, and serves a registered readback port.
module reg_map_responder
  import reg_map_pkg::*;
#(
  parameter logic [31:0] VERSION          = 32'h0001_0000,
  parameter logic [31:0] CHIRP_PERIOD_RST = 32'd10,
  parameter logic [1:0]  MAC_SPEED_RST    = 2'b01
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        reg_map_wr_cmd,
  input  logic [7:0]  reg_map_wr_addr,
  input  logic [31:0] reg_map_wr_data,
  input  logic [31:0] reg_map_wr_keep,
  output logic        reg_map_wr_valid,
  output logic        reg_map_wr_ready,
  output logic [1:0]  reg_map_wr_err,
  input  logic        rd_cmd,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] chirp_period,
  output logic        ddc_duc_bypass,
  output logic        adc_pkt_en,
  output logic [1:0]  mac_speed,
  output logic [3:0]  cfg_update,
  output logic [7:0]  dropped_cmd_cnt
);

  wr_state_e   state_q, state_d;
  logic        ready_q, ready_d;
  logic        wr_valid_q, wr_valid_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] keep_q, keep_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        hit_chirp, hit_ddc, hit_adc, hit_mac;
  logic        wr_phase;
  logic [1:0]  err_code;
  logic [31:0] rd_mux;

  // Decode the captured address; only the WRITE cycle acts on it.
  always_comb begin
    hit_chirp = (addr_q == REG_CHIRP_PERIOD);
    hit_ddc   = (addr_q == REG_DDC_DUC);
    hit_adc   = (addr_q == REG_ADC_PKT);
    hit_mac   = (addr_q == REG_MAC_SPEED);
    wr_phase  = (state_q == ST_WRITE);
    if (hit_chirp || hit_ddc || hit_adc || hit_mac) begin
      err_code = ERR_OK;
    end else if (addr_q == REG_STATUS) begin
      err_code = ERR_RO;
    end else begin
      err_code = ERR_UNMAPPED;
    end
  end

  // Write handshake sequencing, command capture and dropped-command count.
  always_comb begin
    state_d    = state_q;
    wr_valid_d = 1'b0;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    keep_d     = keep_q;
    case (state_q)
      ST_IDLE: begin
        if (reg_map_wr_cmd) begin
          addr_d  = reg_map_wr_addr;
          data_d  = reg_map_wr_data;
          keep_d  = reg_map_wr_keep;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_valid_d = 1'b1;
        err_d      = err_code;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    drop_d  = drop_q;
    if (reg_map_wr_cmd && !ready_q && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Readback mux over the live register outputs; sampled before any
  // same-edge write lands, so a read in the WRITE cycle sees the old value.
  always_comb begin
    case (rd_addr)
      REG_CHIRP_PERIOD: rd_mux = chirp_period;
      REG_DDC_DUC:      rd_mux = {31'b0, ddc_duc_bypass};
      REG_ADC_PKT:      rd_mux = {31'b0, adc_pkt_en};
      REG_MAC_SPEED:    rd_mux = {30'b0, mac_speed};
      REG_STATUS:       rd_mux = VERSION;
      default:          rd_mux = 32'h0;
    endcase
    rd_valid_d = rd_cmd;
    rd_data_d  = rd_cmd ? rd_mux : rd_data_q;
  end

  // Control and response flops, cleared by reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      wr_valid_q <= 1'b0;
      err_q      <= ERR_OK;
      drop_q     <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Captured command payload; only consumed in WRITE, so it needs no reset.
  always_ff @(posedge aclk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    keep_q <= keep_d;
  end

  reg_map_field #(.WIDTH(32), .RST(CHIRP_PERIOD_RST)) u_chirp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_phase && hit_chirp),
    .wr_data (data_q),
    .wr_keep (keep_q),
    .value   (chirp_period),
    .update  (cfg_update[0])
  );

  reg_map_field #(.WIDTH(1), .RST(1'b0)) u_ddc_duc (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_phase && hit_ddc),
    .wr_data (data_q[0:0]),
    .wr_keep (keep_q[0:0]),
    .value   (ddc_duc_bypass),
    .update  (cfg_update[1])
  );

  reg_map_field #(.WIDTH(1), .RST(1'b0)) u_adc_pkt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_phase && hit_adc),
    .wr_data (data_q[0:0]),
    .wr_keep (keep_q[0:0]),
    .value   (adc_pkt_en),
    .update  (cfg_update[2])
  );

  reg_map_field #(.WIDTH(2), .RST(MAC_SPEED_RST)) u_mac_speed (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_phase && hit_mac),
    .wr_data (data_q[1:0]),
    .wr_keep (keep_q[1:0]),
    .value   (mac_speed),
    .update  (cfg_update[3])
  );

  assign reg_map_wr_ready = ready_q;
  assign reg_map_wr_valid = wr_valid_q;
  assign reg_map_wr_err   = err_q;
  assign dropped_cmd_cnt  = drop_q;
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;

endmodule
